regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 119 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with a hardware clear sequence.
// After reset the array walks registers 1..REG_COUNT-1 writing zero, then
// raises ready and accepts writes. Register 0 is hardwired to zero, and
// out-of-range addresses read as zero and drop their writes.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle write data
// to matching read ports; without it a read sees the pre-write value.
module regfile_mp #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = $clog2(REG_COUNT),
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*REG_ADDR_W-1:0] wa,
  input  logic [NUM_WR*XLEN-1:0]       wd,
  input  logic [NUM_RD*REG_ADDR_W-1:0] ra,
  output logic [NUM_RD*XLEN-1:0]       rd,
  output logic                         ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(REG_COUNT - 1);

  state_t                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                    ready_q, ready_d;
  logic [NUM_RD*XLEN-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]         regs_q [REG_COUNT];
  logic [XLEN-1:0]         regs_d [REG_COUNT];

  logic [NUM_WR-1:0]       wr_valid;
  logic [REG_ADDR_W-1:0]   rd_addr;
  logic [XLEN-1:0]         rd_val;

  // True for addresses that name a real, writable register (not x0).
  function automatic logic addr_ok(input logic [REG_ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < REG_COUNT);
  endfunction

  // Qualify each write port: only in RUN, enabled, and to a real register.
  always_comb begin
    wr_valid = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_valid[p] = (state_q == RUN) && we[p] &&
                    addr_ok(wa[p*REG_ADDR_W +: REG_ADDR_W]);
    end
  end

  // Next array contents and control: clear walk in CLEAR, port writes in RUN.
  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == CLEAR) begin
      regs_d[clr_idx_q] = '0;
      clr_idx_d         = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_valid[p]) begin
          regs_d[wa[p*REG_ADDR_W +: REG_ADDR_W]] = wd[p*XLEN +: XLEN];
        end
      end
    end
    regs_d[0] = '0;
  end

  // Next read data per lane; zero during CLEAR and for x0 or out-of-range.
  always_comb begin
    rd_d    = '0;
    rd_addr = '0;
    rd_val  = '0;
    if (state_q == RUN) begin
      for (int q = 0; q < NUM_RD; q++) begin
        rd_addr = ra[q*REG_ADDR_W +: REG_ADDR_W];
        rd_val  = '0;
        if (addr_ok(rd_addr)) begin
          rd_val = regs_q[rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_valid[p] && (wa[p*REG_ADDR_W +: REG_ADDR_W] == rd_addr)) begin
            rd_val = wd[p*XLEN +: XLEN];
          end
        end
`endif
        rd_d[q*XLEN +: XLEN] = rd_val;
      end
    end
  end

  // State, clear index, ready and read data registers; array holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= REG_ADDR_W'(1);
      ready_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      rd_q      <= rd_d;
      regs_q    <= regs_d;
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;

endmodule
